// File: rtl/plic_target_arb.sv
// -----------------------------------------------------------------------------
// plic_target_arb
//
// PLIC target stage. For every target it picks the highest-priority source that
// is pending, enabled for that target, not in service and not being granted in
// the current cycle, and raises the target's interrupt request when that
// priority is strictly above the target threshold. It also owns the per-source
// in-service state, driven by claim (read) and complete (write) accesses.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   src_pending_i  gateway pending bits, bit s-1 is source ID s
//   src_priority_i per-source priority, packed in ID order (ID 1 in the LSBs)
//   enable_i       per-target enable vectors, target t in [t*SOURCES +: SOURCES]
//   threshold_i    per-target threshold, target t in [t*PRIORITY_BITS +: ...]
//   claim_i        per-target claim strobe (one cycle)
//   complete_i     per-target complete strobe (one cycle)
//   complete_id_i  per-target ID written with the complete
//   ireq_o         registered per-target interrupt request
//   id_o           registered per-target best ID (0 = none)
//   claim_id_o     registered ID returned by each target's last claim
//   claimed_o      one-cycle pulse per source granted by a claim
//   in_service_o   sources claimed and not yet completed
// -----------------------------------------------------------------------------
module plic_target_arb #(
    parameter int SOURCES       = 8,
    parameter int PRIORITIES    = 7,
    parameter int TARGETS       = 2,
    parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
    parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SOURCES-1:0]                 src_pending_i,
    input  logic [SOURCES*PRIORITY_BITS-1:0]   src_priority_i,
    input  logic [TARGETS*SOURCES-1:0]         enable_i,
    input  logic [TARGETS*PRIORITY_BITS-1:0]   threshold_i,
    input  logic [TARGETS-1:0]                 claim_i,
    input  logic [TARGETS-1:0]                 complete_i,
    input  logic [TARGETS*SOURCES_BITS-1:0]    complete_id_i,
    output logic [TARGETS-1:0]                 ireq_o,
    output logic [TARGETS*SOURCES_BITS-1:0]    id_o,
    output logic [TARGETS*SOURCES_BITS-1:0]    claim_id_o,
    output logic [SOURCES-1:0]                 claimed_o,
    output logic [SOURCES-1:0]                 in_service_o
);

    // Registered state
    logic [SOURCES-1:0]       r_in_service;
    logic [SOURCES-1:0]       r_claimed;
    logic [TARGETS-1:0]       r_ireq;
    logic [SOURCES_BITS-1:0]  r_id       [TARGETS];
    logic [SOURCES_BITS-1:0]  r_claim_id [TARGETS];

    // Combinational terms
    logic [SOURCES-1:0]       w_grant_now;
    logic [SOURCES-1:0]       w_clear;
    logic [TARGETS-1:0]       w_ireq_nxt;
    logic [SOURCES_BITS-1:0]  w_req_id   [TARGETS];
    logic [SOURCES_BITS-1:0]  w_gnt_id   [TARGETS];
    logic [SOURCES_BITS-1:0]  w_best_id  [TARGETS];
    logic [PRIORITY_BITS-1:0] w_best_pri [TARGETS];

    // -------------------------------------------------------------------------
    // Claim arbitration. A claim only ever grants the registered id_o of a
    // target whose ireq_o is set. Targets are visited in ascending index, so
    // when several claim the same ID the first one marks the source granted
    // and the later ones find the bit already taken and receive 0.
    // -------------------------------------------------------------------------
    always_comb begin
        w_grant_now = '0;
        for (int unsigned t = 0; t < TARGETS; t++) begin
            w_req_id[t] = (claim_i[t] && r_ireq[t]) ? r_id[t] : '0;
            w_gnt_id[t] = '0;
            for (int unsigned s = 0; s < SOURCES; s++) begin
                if ((w_req_id[t] == SOURCES_BITS'(s + 1)) && !w_grant_now[s]) begin
                    w_grant_now[s] = 1'b1;
                    w_gnt_id[t]    = w_req_id[t];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Complete decoding. ID 0 and out-of-range IDs never match any source, so
    // they fall through as no-ops. Several targets completing the same source
    // simply OR into the same clear bit.
    // -------------------------------------------------------------------------
    always_comb begin
        w_clear = '0;
        for (int unsigned t = 0; t < TARGETS; t++) begin
            for (int unsigned s = 0; s < SOURCES; s++) begin
                if (complete_i[t]
                    && (complete_id_i[t*SOURCES_BITS +: SOURCES_BITS] == SOURCES_BITS'(s + 1))
                    && r_in_service[s]
                    && enable_i[t*SOURCES + s]) begin
                    w_clear[s] = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-target selection. Sources are scanned in ascending ID with a strict
    // greater-than, so ties resolve to the lowest ID. Best priority starts at 0
    // and priority-0 sources are never candidates, so "no candidate" leaves the
    // result at ID 0 / priority 0. Sources granted this cycle are masked so the
    // registered id_o never repeats a just-claimed ID.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned t = 0; t < TARGETS; t++) begin
            w_best_id[t]  = '0;
            w_best_pri[t] = '0;
            for (int unsigned s = 0; s < SOURCES; s++) begin
                if (src_pending_i[s]
                    && enable_i[t*SOURCES + s]
                    && !r_in_service[s]
                    && !w_grant_now[s]
                    && (src_priority_i[s*PRIORITY_BITS +: PRIORITY_BITS] != '0)
                    && (src_priority_i[s*PRIORITY_BITS +: PRIORITY_BITS] > w_best_pri[t])) begin
                    w_best_id[t]  = SOURCES_BITS'(s + 1);
                    w_best_pri[t] = src_priority_i[s*PRIORITY_BITS +: PRIORITY_BITS];
                end
            end
            w_ireq_nxt[t] = (w_best_pri[t] > threshold_i[t*PRIORITY_BITS +: PRIORITY_BITS]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_service <= '0;
            r_claimed    <= '0;
            r_ireq       <= '0;
            for (int unsigned t = 0; t < TARGETS; t++) begin
                r_id[t]       <= '0;
                r_claim_id[t] <= '0;
            end
        end else begin
            // A granted source was a candidate last cycle, hence not in
            // service, so a clear and a grant never hit the same bit.
            r_in_service <= (r_in_service & ~w_clear) | w_grant_now;
            r_claimed    <= w_grant_now;
            r_ireq       <= w_ireq_nxt;
            for (int unsigned t = 0; t < TARGETS; t++) begin
                r_id[t] <= w_best_id[t];
                if (claim_i[t]) begin
                    r_claim_id[t] <= w_gnt_id[t];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output packing
    // -------------------------------------------------------------------------
    always_comb begin
        id_o       = '0;
        claim_id_o = '0;
        for (int unsigned t = 0; t < TARGETS; t++) begin
            id_o[t*SOURCES_BITS +: SOURCES_BITS]       = r_id[t];
            claim_id_o[t*SOURCES_BITS +: SOURCES_BITS] = r_claim_id[t];
        end
    end

    assign ireq_o       = r_ireq;
    assign claimed_o    = r_claimed;
    assign in_service_o = r_in_service;

endmodule

// File: doc/plic_target_arb.md
Name: plic_target_arb

Overview:
Multi-target PLIC target stage with claim/complete tracking. For each of TARGETS targets it selects the highest-priority pending, enabled, not-in-service source and raises the interrupt request when that priority exceeds the target threshold. It owns the per-source in-service state. It sits between the gateways and priority/enable registers on one side and the bus register interface (claim/complete accesses) on the other.

Parameters:
SOURCES, 8, number of interrupt sources; IDs 1..SOURCES, ID 0 reserved for "none"
PRIORITIES, 7, number of priority levels; priority 0 never interrupts
TARGETS, 2, number of interrupt targets (hart contexts)
SOURCES_BITS, $clog2(SOURCES+1), ID width
PRIORITY_BITS, $clog2(PRIORITIES), priority/threshold width

Ports:
rst_n  in  1  asynchronous active-low reset
clk  in  1  system clock, rising edge
src_pending_i  in  SOURCES  gateway pending bits; bit s-1 is ID s
src_priority_i  in  SOURCES*PRIORITY_BITS  per-source priority, packed in ID order
enable_i  in  TARGETS*SOURCES  per-target enable vectors
threshold_i  in  TARGETS*PRIORITY_BITS  per-target threshold
claim_i  in  TARGETS  claim-register read strobe, one cycle
complete_i  in  TARGETS  complete-register write strobe, one cycle
complete_id_i  in  TARGETS*SOURCES_BITS  ID written with complete
ireq_o  out  TARGETS  interrupt request (EIP), registered
id_o  out  TARGETS*SOURCES_BITS  current best ID per target, registered
claim_id_o  out  TARGETS*SOURCES_BITS  ID returned by the last claim, registered
claimed_o  out  SOURCES  one-cycle pulse per claimed source (clears gateway pending)
in_service_o  out  SOURCES  sources claimed and not yet completed

Behaviour:
- Reset (async, rst_n low): ireq_o=0, id_o=0, claim_id_o=0, claimed_o=0, in_service_o=0. Takes effect immediately regardless of clk, including mid-service. All in-service state is lost.
- Candidate for target t, source s: src_pending_i[s] & enable_i[t][s] & ~in_service[s] & ~grant_now[s] & (priority[s]!=0).
- Selection: highest priority among candidates. A tie goes to the lowest ID. No candidate gives best ID 0, best priority 0.
- id_o[t] <= best ID. ireq_o[t] <= (best priority > threshold_i[t]), unsigned compare. Latency is 1 cycle from any input change to id_o/ireq_o.
- Claim, per target t, when claim_i[t]=1:
  - Granted ID g = id_o[t] if ireq_o[t]=1, else 0.
  - claim_id_o[t] <= g on the same edge; claim_id_o holds until the next claim by t.
  - If g!=0: in_service[g] <= 1 and claimed_o[g] pulses high for exactly the following cycle.
- Simultaneous claims of the same nonzero ID by several targets: the lowest target index wins. The others receive claim_id_o=0 and set nothing.
- grant_now (combinational) masks sources granted this cycle out of selection. id_o/ireq_o therefore never present a just-claimed ID in the cycle after the claim: no stale repeat.
- Complete, per target t, when complete_i[t]=1 and id c=complete_id_i[t]:
  - If c in 1..SOURCES, in_service[c]=1 and enable_i[t][c]=1: in_service[c] <= 0.
  - Otherwise (c=0, out of range, not in service, not enabled) the complete is silently ignored.
- Complete and claim in the same cycle are both applied. A complete clears the bit a cycle earlier than any new claim could set it; no conflict exists, since an in-service ID cannot be granted.
- Several targets completing the same ID in one cycle: a single clear.
- Threshold or enable changes take effect on the next edge. An in-flight claim uses the registered id_o/ireq_o only.
- Threshold = PRIORITIES-1 (max) masks all requests for that target; claim then returns 0.

Test Plan:
- Reset: with src_pending_i=all ones and all enabled, assert rst_n=0 -> all outputs 0 with no clock edge. Release -> next edge id_o[0]=best ID.
- Priority/tie: SOURCES=8, pending IDs 3,5,6, priorities 2,4,4, threshold 1 -> id_o=5, ireq_o=1 one cycle after. Set priority[5]=0 -> id_o=6.
- Threshold: best priority 3, threshold 3 -> ireq_o=0, claim returns 0, no claimed_o. Threshold 2 -> ireq_o=1.
- Claim/complete: claim on target 0 with id_o=5 -> claim_id_o=5, claimed_o[5] pulses 1 cycle, in_service_o[5]=1, id_o moves to next candidate with no repeat of 5. Complete(5) -> in_service_o[5]=0 and 5 is selectable again.
- Contention: targets 0 and 1 both see ID 4 and claim in the same cycle -> target 0 gets 4, target 1 gets 0, a single claimed_o[4] pulse.
- Invalid completes: complete_id 0, 9, a not-in-service ID, and an ID not enabled for the target -> in_service_o unchanged. Reset asserted mid-service -> in_service_o cleared.
